// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//
// Purpose:
//   Single-port word memory behind a simple req/ready handshake. Each access
//   takes WAIT_CYCLES wait states and then one response cycle. The memory
//   is performed on the edge that enters the response state. Addresses at or
//   above DEPTH are flagged with err and never touch the array.
//
// Parameters:
//   WORD_SIZE   data word width
//   ADDR_SIZE   address width
//   DEPTH       number of implemented words (1 .. 2**ADDR_SIZE)
//   WAIT_CYCLES wait states per access (0 .. 15)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        access request, only looked at while idle
//   we         1 = write, 0 = read (sampled with req)
//   addr       access address (sampled with req)
//   wdata      write data (sampled with req)
//   rdata      registered read data, updated only by completed reads
//   ready      one-cycle completion pulse (the response cycle)
//   busy       high whenever an access is in progress
//   err        out-of-range flag, meaningful only while ready=1
//
// Optional feature (macro MEMORY_RESPONDER_PARITY_EN):
//   par_inject  inverts the stored even-parity bit on a write
//   parity_err  high in the response cycle of an in-range read whose stored
//               parity does not match
// -----------------------------------------------------------------------------
module memory_responder #(
    parameter int WORD_SIZE   = 8,
    parameter int ADDR_SIZE   = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
`ifdef MEMORY_RESPONDER_PARITY_EN
    input  logic                 par_inject,
`endif
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 ready,
    output logic                 busy,
    output logic                 err
`ifdef MEMORY_RESPONDER_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef MEMORY_RESPONDER_PARITY_EN
    localparam int MEM_W = WORD_SIZE + 1;
`else
    localparam int MEM_W = WORD_SIZE;
`endif

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [ADDR_SIZE-1:0] r_addr;
    logic                 r_we;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_rdata;
    logic                 r_err;
    logic [MEM_W-1:0]     r_mem [0:DEPTH-1];

`ifdef MEMORY_RESPONDER_PARITY_EN
    logic                 r_pinj;
    logic                 r_perr;
    logic                 w_acc_pinj;
`endif

    logic                 w_idle;
    logic                 w_fire;
    logic [ADDR_SIZE-1:0] w_acc_addr;
    logic                 w_acc_we;
    logic [WORD_SIZE-1:0] w_acc_wdata;
    logic [31:0]          w_addr_ext;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;
    logic [MEM_W-1:0]     w_wr_word;

    assign w_idle = (r_state == S_IDLE);

    // w_fire marks the edge that enters S_RESP. With no wait states that edge
    // is the capture edge itself, so the access uses the live inputs instead
    // of the capture registers.
    assign w_fire = ((WAIT_CYCLES == 0) && w_idle && req) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));

    assign w_acc_addr  = w_idle ? addr  : r_addr;
    assign w_acc_we    = w_idle ? we    : r_we;
    assign w_acc_wdata = w_idle ? wdata : r_wdata;

    assign w_addr_ext = 32'(w_acc_addr);
    assign w_in_range = (w_addr_ext < 32'(DEPTH));
    assign w_idx      = w_acc_addr[IDX_W-1:0];

`ifdef MEMORY_RESPONDER_PARITY_EN
    assign w_acc_pinj = w_idle ? par_inject : r_pinj;
    // Even parity: the stored bit makes the word's total count of ones even.
    assign w_wr_word  = {(^w_acc_wdata) ^ w_acc_pinj, w_acc_wdata};
`else
    assign w_wr_word  = w_acc_wdata;
`endif

    // Control FSM. Reset wins over everything, which also discards a
    // request or completion that coincides with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_fire && !w_in_range;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture registers only load in idle, so they are frozen mid-access.
    always_ff @(posedge clk) begin
        if (w_idle && req) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
`ifdef MEMORY_RESPONDER_PARITY_EN
            r_pinj  <= par_inject;
`endif
        end
    end

    // Memory array: no reset so it maps onto block RAM and keeps its
    // contents across reset.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_acc_we && w_in_range) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    // Registered read port; out-of-range reads return zero, writes leave
    // the last read value in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_fire && !w_acc_we) begin
            r_rdata <= w_in_range ? r_mem[w_idx][WORD_SIZE-1:0] : '0;
        end
    end

`ifdef MEMORY_RESPONDER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_fire && !w_acc_we && w_in_range && (^r_mem[w_idx]);
        end
    end
    assign parity_err = r_perr;
`endif

    assign rdata = r_rdata;
    assign ready = (r_state == S_RESP);
    assign busy  = !w_idle;
    assign err   = r_err;

endmodule
